// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment capture path.
// Segment patterns are active-low: bit 7 = dp, bits 6:0 = g..a.
package seg_pkg;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'hFE;
  localparam logic [7:0] SEG_B = 8'hFD;
  localparam logic [7:0] SEG_C = 8'hFB;
  localparam logic [7:0] SEG_D = 8'hF7;
  localparam logic [7:0] SEG_E = 8'hEF;
  localparam logic [7:0] SEG_F = 8'hDF;

  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [7:0] SEG_DP_MASK = 8'h80;

  // Digit select is active-low one-hot; all-ones means no digit driven.
  localparam logic [3:0] SEL_DIG0 = 4'b1110;
  localparam logic [3:0] SEL_DIG1 = 4'b1101;
  localparam logic [3:0] SEL_DIG2 = 4'b1011;
  localparam logic [3:0] SEL_DIG3 = 4'b0111;
  localparam logic [3:0] SEL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SEL_CLASS_IDLE    = 2'd0,
    SEL_CLASS_DIGIT   = 2'd1,
    SEL_CLASS_ILLEGAL = 2'd2
  } sel_class_e;

  typedef struct packed {
    sel_class_e  cls;
    logic [1:0]  idx;
  } sel_dec_t;

  // Classify a registered select code into idle / digit n / illegal.
  function automatic sel_dec_t decode_sel(input logic [3:0] sel);
    sel_dec_t d;
    d.cls = SEL_CLASS_ILLEGAL;
    d.idx = 2'd0;
    case (sel)
      SEL_DIG0: begin d.cls = SEL_CLASS_DIGIT; d.idx = 2'd0; end
      SEL_DIG1: begin d.cls = SEL_CLASS_DIGIT; d.idx = 2'd1; end
      SEL_DIG2: begin d.cls = SEL_CLASS_DIGIT; d.idx = 2'd2; end
      SEL_DIG3: begin d.cls = SEL_CLASS_DIGIT; d.idx = 2'd3; end
      SEL_IDLE: begin d.cls = SEL_CLASS_IDLE;  d.idx = 2'd0; end
      default:  begin d.cls = SEL_CLASS_ILLEGAL; d.idx = 2'd0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-low 7-segment pattern.
// The dp bit is masked off before the table lookup and reported separately.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] nibble,
  output logic       dp,
  output logic       blank,
  output logic       hit
);

  logic [7:0] key_s;

  assign key_s = pattern | SEG_DP_MASK;
  assign dp    = ~pattern[7];
  assign blank = (pattern == SEG_OFF);

  // Map the dp-stripped pattern to its hex value; anything else is a miss.
  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (key_s)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: begin
        nibble = 4'h0;
        hit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Captures a multiplexed active-low 7-segment bus and rebuilds a coherent
// 4-digit frame (hex nibbles, dp flags, blank flags) with a valid strobe.
module seg_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_seg,
  input  logic [3:0]  i_sel,
  output logic [15:0] o_data,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_turn_off,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_stale
);

  localparam logic [7:0]  STABLE_V  = 8'(STABLE_CYCLES);
  localparam logic [7:0]  STABLE_M1 = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] TO_V      = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TO_M1     = 16'(TIMEOUT_CYCLES - 1);

  logic [7:0]  seg_r, seg_prev_r;
  logic [3:0]  sel_r, sel_prev_r;
  logic [7:0]  stab_cnt_r;
  logic [3:0]  mask_r;
  logic [15:0] sh_data_r;
  logic [3:0]  sh_dp_r;
  logic [3:0]  sh_off_r;
  logic [15:0] to_cnt_r;

  logic        same_s;
  logic        accept_s;
  sel_dec_t    sel_dec_s;
  logic [3:0]  nib_s;
  logic        dp_s, blank_s, hit_s;
  logic        digit_ok_s;
  logic        err_s;
  logic        complete_s;
  logic        timeout_s;

  seg7_to_hex u_dec (
    .pattern (seg_r),
    .nibble  (nib_s),
    .dp      (dp_s),
    .blank   (blank_s),
    .hit     (hit_s)
  );

  assign same_s     = ({sel_r, seg_r} == {sel_prev_r, seg_prev_r});
  // Fires only on the step into STABLE_CYCLES, so a long dwell accepts once.
  assign accept_s   = same_s && (stab_cnt_r == STABLE_M1);
  assign sel_dec_s  = decode_sel(sel_r);
  assign complete_s = (mask_r == 4'hF);
  // A valid accept in the timeout cycle wins: no stale, counter reloads.
  assign timeout_s  = !digit_ok_s && (to_cnt_r == TO_M1);

  // Classify an accepted sample into valid digit, ignored idle, or error.
  always_comb begin
    digit_ok_s = 1'b0;
    err_s      = 1'b0;
    if (accept_s) begin
      case (sel_dec_s.cls)
        SEL_CLASS_IDLE: begin
          digit_ok_s = 1'b0;
          err_s      = 1'b0;
        end
        SEL_CLASS_DIGIT: begin
          if (blank_s || hit_s) begin
            digit_ok_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end
        default: err_s = 1'b1;
      endcase
    end else begin
      digit_ok_s = 1'b0;
      err_s      = 1'b0;
    end
  end

  // Input register stage plus one-cycle history for change detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seg_r      <= SEG_OFF;
      sel_r      <= SEL_IDLE;
      seg_prev_r <= SEG_OFF;
      sel_prev_r <= SEL_IDLE;
    end else begin
      seg_r      <= i_seg;
      sel_r      <= i_sel;
      seg_prev_r <= seg_r;
      sel_prev_r <= sel_r;
    end
  end

  // Stability counter: reload on change, count up and saturate while steady.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stab_cnt_r <= 8'd0;
    end else if (!same_s) begin
      stab_cnt_r <= 8'd1;
    end else if (stab_cnt_r != STABLE_V) begin
      stab_cnt_r <= stab_cnt_r + 8'd1;
    end else begin
      stab_cnt_r <= stab_cnt_r;
    end
  end

  // Captured-digit mask: set per valid digit, cleared on frame end/error/timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask_r <= 4'h0;
    end else if (digit_ok_s) begin
      mask_r <= mask_r | (4'b0001 << sel_dec_s.idx);
    end else if (complete_s || err_s || timeout_s) begin
      mask_r <= 4'h0;
    end else begin
      mask_r <= mask_r;
    end
  end

  // Shadow frame: written per accepted digit; blank keeps the old nibble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_data_r <= 16'h0000;
      sh_dp_r   <= 4'h0;
      sh_off_r  <= 4'hF;
    end else if (digit_ok_s) begin
      if (blank_s) begin
        sh_dp_r[sel_dec_s.idx]  <= 1'b0;
        sh_off_r[sel_dec_s.idx] <= 1'b1;
      end else begin
        sh_data_r[{sel_dec_s.idx, 2'b00} +: 4] <= nib_s;
        sh_dp_r[sel_dec_s.idx]                 <= dp_s;
        sh_off_r[sel_dec_s.idx]                <= 1'b0;
      end
    end
  end

  // Timeout counter: cleared by every valid digit, otherwise saturating count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt_r <= 16'd0;
    end else if (digit_ok_s) begin
      to_cnt_r <= 16'd0;
    end else if (to_cnt_r != TO_V) begin
      to_cnt_r <= to_cnt_r + 16'd1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Output frame, strobes and stale flag; frame copy is atomic on completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data     <= 16'h0000;
      o_dp       <= 4'h0;
      o_turn_off <= 4'hF;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_stale    <= 1'b1;
    end else begin
      o_valid <= complete_s;
      o_err   <= err_s;
      if (complete_s) begin
        o_data     <= sh_data_r;
        o_dp       <= sh_dp_r;
        o_turn_off <= sh_off_r;
        o_stale    <= 1'b0;
      end else if (timeout_s) begin
        o_stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: drives a display-scan model and
// compares the rebuilt frames against a digit-level reference model.
module tb_seg_capture;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_seg = 8'hFF;
  logic [3:0]  i_sel = 4'hF;
  logic [15:0] o_data;
  logic [3:0]  o_dp;
  logic [3:0]  o_turn_off;
  logic        o_valid;
  logic        o_err;
  logic        o_stale;

  int checks = 0;
  int errors = 0;

  // Monitor counters, updated 1 time unit after each rising edge.
  int   valid_cnt = 0;
  int   err_cnt   = 0;
  logic stale_prev = 1'b1;
  logic stale_at_valid = 1'b1;
  logic stale_before_valid = 1'b0;

  // Reference model state.
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
  logic [3:0] held   [4];
  logic [3:0] fr_nib [4];
  logic       fr_dp  [4];
  logic       fr_off [4];
  int         exp_valid = 0;
  int         exp_err   = 0;

  seg_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(32768)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_seg      (i_seg),
    .i_sel      (i_sel),
    .o_data     (o_data),
    .o_dp       (o_dp),
    .o_turn_off (o_turn_off),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .o_stale    (o_stale)
  );

  always #5 i_clk = ~i_clk;

  // Pulse counting and stale-at-valid capture.
  always @(posedge i_clk) begin
    #1;
    if (o_valid) begin
      valid_cnt++;
      stale_at_valid     = o_stale;
      stale_before_valid = stale_prev;
    end
    if (o_err) err_cnt++;
    stale_prev = o_stale;
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data_f();
    logic [15:0] r;
    for (int d = 0; d < 4; d++) r[4*d +: 4] = fr_nib[d];
    return r;
  endfunction

  function automatic logic [3:0] exp_dp_f();
    logic [3:0] r;
    for (int d = 0; d < 4; d++) r[d] = fr_dp[d];
    return r;
  endfunction

  function automatic logic [3:0] exp_off_f();
    logic [3:0] r;
    for (int d = 0; d < 4; d++) r[d] = fr_off[d];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      held[d] = 4'h0; fr_nib[d] = 4'h0; fr_dp[d] = 1'b0; fr_off[d] = 1'b1;
    end
  endtask

  // Show one digit on the bus for dwell cycles and record what a display shows.
  task automatic show_digit(input int d, input logic [3:0] nib, input logic dpv, input logic offv, input int dwell);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    i_sel = ~oh;
    if (offv) begin
      i_seg = 8'hFF;
    end else begin
      i_seg = seg_tab[nib];
      if (dpv) i_seg[7] = 1'b0;
    end
    repeat (dwell) @(negedge i_clk);
    if (!offv) held[d] = nib;
    fr_nib[d] = held[d];
    fr_dp[d]  = offv ? 1'b0 : dpv;
    fr_off[d] = offv;
  endtask

  task automatic idle(input int cycles);
    i_sel = 4'hF;
    i_seg = 8'hFF;
    repeat (cycles) @(negedge i_clk);
  endtask

  // One full scan: four digit slots then four idle slots.
  task automatic scan(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] off, input int dwell);
    for (int d = 0; d < 4; d++) show_digit(d, data[4*d +: 4], dp[d], off[d], dwell);
    idle(4 * dwell);
    exp_valid++;
  endtask

  task automatic check_frame(input string tag);
    chk(tag, "valid_count", 32'(valid_cnt), 32'(exp_valid));
    chk(tag, "err_count",   32'(err_cnt),   32'(exp_err));
    chk(tag, "data",        32'(o_data),     32'(exp_data_f()));
    chk(tag, "dp",          32'(o_dp),       32'(exp_dp_f()));
    chk(tag, "turn_off",    32'(o_turn_off), 32'(exp_off_f()));
  endtask

  task automatic check_reset(input string tag);
    chk(tag, "data",     32'(o_data),     32'h0);
    chk(tag, "dp",       32'(o_dp),       32'h0);
    chk(tag, "turn_off", 32'(o_turn_off), 32'hF);
    chk(tag, "valid",    32'(o_valid),    32'h0);
    chk(tag, "err",      32'(o_err),      32'h0);
    chk(tag, "stale",    32'(o_stale),    32'h1);
  endtask

  initial begin
    logic [15:0] rd, pd;
    logic [3:0]  rp, ro, pp, po;
    int          dw;

    model_reset();
    repeat (3) @(negedge i_clk);
    check_reset("reset");
    i_rst = 1'b0;

    // Loopback with a slow driver: two scans, one frame each.
    scan(16'h1A3F, 4'b0100, 4'b0000, 2048);
    scan(16'h1A3F, 4'b0100, 4'b0000, 2048);
    check_frame("loop");
    chk("loop", "stale", 32'(o_stale), 32'h0);

    // Blank digit 3 keeps its old nibble and drops dp.
    scan(16'h1A3F, 4'b0100, 4'b1000, 16);
    check_frame("blank");

    // Random frames with random dwell.
    for (int k = 0; k < 12; k++) begin
      rd = 16'($urandom);
      rp = 4'($urandom);
      ro = 4'($urandom);
      dw = $urandom_range(8, 14);
      scan(rd, rp, ro, dw);
      check_frame("rand");
    end

    // Glitch on digit 2: short-lived pattern, then settles on 4.
    show_digit(0, 4'h5, 1'b0, 1'b0, 12);
    show_digit(1, 4'hC, 1'b1, 1'b0, 12);
    i_sel = 4'b1011;
    i_seg = seg_tab[7];
    repeat (2) @(negedge i_clk);
    show_digit(2, 4'h4, 1'b0, 1'b0, 16);
    show_digit(3, 4'h9, 1'b0, 1'b0, 12);
    idle(64);
    exp_valid++;
    check_frame("glitch");

    // Illegal select held exactly 4 cycles aborts the partial frame.
    pd = exp_data_f(); pp = exp_dp_f(); po = exp_off_f();
    show_digit(0, 4'h2, 1'b0, 1'b0, 12);
    show_digit(1, 4'h7, 1'b0, 1'b0, 12);
    i_sel = 4'b1100;
    i_seg = 8'hC0;
    repeat (4) @(negedge i_clk);
    idle(64);
    exp_err++;
    chk("illegal", "valid_count", 32'(valid_cnt), 32'(exp_valid));
    chk("illegal", "err_count",   32'(err_cnt),   32'(exp_err));
    chk("illegal", "data",        32'(o_data),     32'(pd));
    chk("illegal", "dp",          32'(o_dp),       32'(pp));
    chk("illegal", "turn_off",    32'(o_turn_off), 32'(po));
    scan(16'hB072, 4'b0011, 4'b0000, 12);
    check_frame("after_illegal");

    // Unrecognised pattern 7F on digit 1.
    pd = exp_data_f(); pp = exp_dp_f(); po = exp_off_f();
    show_digit(0, 4'hE, 1'b1, 1'b0, 12);
    i_sel = 4'b1101;
    i_seg = 8'h7F;
    repeat (8) @(negedge i_clk);
    idle(64);
    exp_err++;
    chk("bad_pat", "valid_count", 32'(valid_cnt), 32'(exp_valid));
    chk("bad_pat", "err_count",   32'(err_cnt),   32'(exp_err));
    chk("bad_pat", "data",        32'(o_data),     32'(pd));
    chk("bad_pat", "dp",          32'(o_dp),       32'(pp));
    chk("bad_pat", "turn_off",    32'(o_turn_off), 32'(po));

    // Stale after a long idle, cleared together with the next valid.
    scan(16'h3C5A, 4'b1001, 4'b0000, 16);
    check_frame("pre_stale");
    idle(32600);
    chk("stale_early", "stale", 32'(o_stale), 32'h0);
    idle(200);
    chk("stale_set", "stale", 32'(o_stale), 32'h1);
    scan(16'($urandom), 4'($urandom), 4'b0000, 16);
    check_frame("resume");
    chk("resume", "stale_at_valid",     32'(stale_at_valid),     32'h0);
    chk("resume", "stale_before_valid", 32'(stale_before_valid), 32'h1);
    chk("resume", "stale_now",          32'(o_stale),            32'h0);

    // Reset after two accepted digits: progress lost, four fresh accepts needed.
    show_digit(0, 4'h8, 1'b0, 1'b0, 12);
    show_digit(1, 4'h6, 1'b0, 1'b0, 12);
    i_sel = 4'hF;
    i_seg = 8'hFF;
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset("mid_reset");
    i_rst = 1'b0;
    model_reset();
    rd = 16'($urandom);
    rp = 4'($urandom);
    ro = 4'($urandom);
    for (int d = 0; d < 3; d++) show_digit(d, rd[4*d +: 4], rp[d], ro[d], 12);
    chk("post_reset", "no_valid_yet", 32'(valid_cnt), 32'(exp_valid));
    show_digit(3, rd[15:12], rp[3], ro[3], 12);
    idle(48);
    exp_valid++;
    check_frame("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Decodes the multiplexed, active-low 7-segment bus (8-bit segment pattern plus 4-bit digit select) back into a 16-bit hex value, per-digit decimal-point flags and per-digit blank flags.
- Used on the expansion board for display loopback self-test and for monitoring a display bus driven by another board.
- Sits on the same clock as the display driver.
- Publishes a complete, coherent 4-digit frame with a one-cycle valid strobe.

Parameters:
- STABLE_CYCLES, 4: consecutive identical {sel,seg} samples required before a digit is accepted. Legal range 2..255.
- TIMEOUT_CYCLES, 32768: cycles without any accepted digit before o_stale asserts. 16-bit counter.

Ports:
- i_clk  in  1: system clock.
- i_rst  in  1: reset. Synchronous, active-high.
- i_seg  in  8: segment pattern, active-low. Bit 7 = dp, bits 6:0 = g..a.
- i_sel  in  4: digit select, active-low one-hot. Bit 0 = digit 0 (least significant nibble).
- o_data  out  16: decoded nibbles of the last complete frame. Digit n maps to [4n+3:4n].
- o_dp  out  4: dp flag per digit, 1 = dp lit.
- o_turn_off  out  4: blank flag per digit, 1 = digit dark.
- o_valid  out  1: one-cycle pulse when o_data/o_dp/o_turn_off update.
- o_err  out  1: one-cycle pulse on an illegal select code or an unrecognised pattern.
- o_stale  out  1: level, no frame received within the timeout.

Behaviour:
- Reset values: o_data=0, o_dp=0, o_turn_off=4'hF, o_valid=0, o_err=0, o_stale=1. Reset also clears the stability counter, the captured-digit mask, the shadow registers and the timeout counter.
- Input stage: i_seg/i_sel are registered once. All decisions use the registered values.
- Stability counter:
  - Increments, saturating at STABLE_CYCLES, while the registered {sel,seg} equals the previous cycle's value.
  - Reloads to 1 on any change.
- Accept event: fires exactly once per stable dwell, on the cycle the counter first reaches STABLE_CYCLES. It does not fire again until {sel,seg} changes.
- Select classification at accept:
  - 1110/1101/1011/0111 select digit 0/1/2/3.
  - 1111 = idle: ignored, no effect on any state.
  - Any other code: error.
- Pattern classification:
  - seg==8'hFF: blank. Shadow turn_off=1, dp=0, nibble shadow unchanged.
  - Otherwise look up (seg | 8'h80) in the 16-entry table: C0 0, F9 1, A4 2, B0 3, 99 4, 92 5, 82 6, F8 7, 80 8, 90 9, FE A, FD B, FB C, F7 D, EF E, DF F.
  - Hit: nibble = table index, dp = ~seg[7], turn_off = 0.
  - Miss, including 8'h7F: error.
- Valid digit accept: write that digit's shadow nibble/dp/turn_off and set its mask bit. A re-accept of an already-masked digit overwrites its shadow.
- Frame completion: on the cycle after the mask becomes 4'hF:
  - shadows copy to outputs atomically;
  - o_valid=1 for one cycle;
  - mask clears;
  - o_stale clears.
- Error:
  - o_err=1 for one cycle, the cycle after the accept event.
  - Mask clears and the partial frame is discarded.
  - Outputs are untouched; shadows are kept.
  - Error and completion are mutually exclusive by construction.
- Timeout counter:
  - Resets on every valid digit accept and increments otherwise, saturating.
  - On reaching TIMEOUT_CYCLES: o_stale=1 and mask clears.
  - A valid accept in the same cycle as the timeout takes priority: counter reloads and no stale is set.
- Latency: a digit is accepted STABLE_CYCLES+1 cycles after its pattern first appears at the pins. o_valid follows the 4th accept by 1 cycle.
- Reset mid-frame: all progress is lost; the first o_valid after reset requires 4 fresh accepts.

Decomposition:
- Shared package seg_pkg:
  - SEG_0..SEG_F pattern constants, SEG_OFF=8'hFF, SEG_DP_MASK=8'h80;
  - SEL_DIG0..SEL_DIG3 and SEL_IDLE codes.
- Sub-module seg7_to_hex: combinational lookup. Input 8-bit pattern; outputs nibble, dp, blank, hit.
- Stability, mask, shadow and timeout logic stay in seg_capture.

Test Plan:
- Loopback from a display-driver model (digit dwell 2048 cycles, idle slots on addresses 4..7), data=16'h1A3F, dp=4'b0100, off=0 → o_data=1A3F, o_dp=0100, o_turn_off=0000; o_valid pulses once per 16384 cycles; o_err never asserts.
- Same stimulus, then off=4'b1000 → next frame gives o_turn_off=1000, o_data[15:12]=1 (held), o_dp[3]=0.
- Glitch: digit 2 pattern changes after 2 stable cycles then settles to 8'h99 → exactly one accept with nibble 4; no error.
- Illegal sel=4'b1100 held 4 cycles → o_err one pulse; the frame in progress yields no o_valid; the next full frame restores o_valid.
- Pattern 8'h7F on digit 1 → o_err pulse, outputs unchanged.
- Hold sel=4'hF for 32768 cycles after a frame → o_stale=1; resume scanning → o_stale=0 coincident with the next o_valid.
- Assert i_rst after 2 digits accepted → all outputs at reset values next cycle; o_valid only after 4 new accepts.
